shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Control FSM for the 8-bit LED shift-register datapath. It loads a start pattern into the register, then issues timed shift commands (right, left or ping-pong) at a programmable tick rate for a programmed number of steps. It sits between the board switches/buttons and the shift register, driving that register's load, data and function inputs.

## Interface
Parameters:
- DIV_W, 24, width of the tick prescaler and of `div`.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- clear  in  1  asynchronous, active-high reset
- start  in  1  begin a sequence; sampled in IDLE only
- stop  in  1  abort the current sequence; sampled in LOAD/RUN
- pattern  in  8  start pattern, latched on accepted `start`
- mode  in  2  00 hold, 01 right, 10 left, 11 bounce; latched on `start`
- steps  in  4  shift count; 0 = run until `stop`; latched on `start`
- div  in  DIV_W  tick period minus 1; latched on `start`
- sh_load  out  1  load strobe to the shift register
- sh_data  out  8  load data to the shift register
- sh_func  out  2  shift command: 00 none, 01 right (>>1), 10 left (<<1)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- step_cnt  out  4  shifts issued in the current sequence

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: all outputs 0. When `start`=1, latch pattern/mode/steps/div and go to LOAD.
- LOAD: for exactly one cycle, sh_load=1 and sh_data=latched pattern. Then go to RUN with prescaler=0, step_cnt=0.
- RUN:
  - The prescaler counts 0..div.
  - On a cycle where prescaler==div (a tick), sh_func carries the current direction for that cycle only. The prescaler returns to 0 and step_cnt increments.
  - On every other cycle, sh_func=00.
- Direction by mode:
  - Right: 01.
  - Left: 10.
  - Hold: ticks still count as steps, but sh_func stays 00.
  - Bounce: starts right. An internal position counter (0..7) increments per tick. When it reaches 7, direction toggles and position returns to 0, giving 7 rights then 7 lefts, repeating.
- Completion: if steps≠0 and the tick makes step_cnt equal steps, go to DONE. If steps=0, stay in RUN; step_cnt wraps 15→0.
- DONE: done=1 for one cycle, then go to IDLE. step_cnt holds its final value until the next accepted `start`.
- `stop`=1 in LOAD or RUN: go to IDLE next edge. No done pulse. No sh_func is issued in that cycle, even on a tick.
- `start` while busy is ignored. `stop` in IDLE is ignored.
- `clear` asserted at any time (including mid-RUN): state IDLE, prescaler 0, step_cnt 0, direction right, position 0, all outputs 0. This takes effect immediately, without waiting for a clock edge.

## Timing
- Outputs are decoded from registered state: sh_load, sh_data, sh_func, busy and done are valid during the cycle and are sampled by the datapath at the next edge.
- `start` sampled at edge E0 → LOAD for cycle E0–E1 → RUN from E1.
- First tick is at RUN cycle index div (0-based). Subsequent ticks follow every div+1 cycles. With div=0, a tick occurs every RUN cycle.
- Latency from `start` to first sh_func pulse: div+2 cycles.
- Last tick is followed by one DONE cycle, then IDLE. busy falls one cycle after done.
- Changes on latched inputs during a sequence have no effect.

## Configuration
- SHIFT_SEQ_REPEAT_EN defined:
  - Adds input `repeat` (1 bit), latched on `start`.
  - If latched `repeat`=1 when steps complete, the FSM pulses done for one cycle and re-enters LOAD instead of DONE/IDLE. The pattern reloads and step_cnt resets, continuing until `stop` or `clear`.
- SHIFT_SEQ_REPEAT_EN undefined: the `repeat` port is absent and every finite sequence ends in IDLE.

## Test plan
- Reset: assert clear mid-RUN with mode=01, div=5 → busy, sh_func, sh_load, done and step_cnt read 0 while clear is high, and the sequence does not resume after release.
- Right run: pattern=0x80, mode=01, steps=3, div=0, start at cycle 0 → sh_load=1 with sh_data=0x80 in cycle 1; sh_func=01 in cycles 2–4; done in cycle 5; busy=0 from cycle 6; step_cnt=3.
- Prescaler: mode=10, steps=2, div=3 → sh_func=10 only at cycles 5 and 9; done at cycle 10.
- Bounce: mode=11, steps=0, div=0 → 7 cycles of sh_func=01, then 7 of 10, then 01 again; step_cnt wraps 15→0.
- Stop/tick collision and ignored start: assert stop on the same cycle as a tick → no sh_func that cycle, no done, IDLE next. Pulse start while busy → no reload and latched values unchanged.
- Repeat (SHIFT_SEQ_REPEAT_EN): repeat=1, steps=2, div=0 → done pulses every 4 cycles with sh_load reasserted each time, until stop.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Control and command bundle between the board controls and shift_sequencer.
// The repeat_en member exists only when SHIFT_SEQ_REPEAT_EN is defined.
interface shift_sequencer_if #(
   parameter int DIV_W = 24
);
   logic             start;
   logic             stop;
   logic [7:0]       pattern;
   logic [1:0]       mode;
   logic [3:0]       steps;
   logic [DIV_W-1:0] div;
`ifdef SHIFT_SEQ_REPEAT_EN
   // "repeat" is a reserved word, so the repeat request is carried as repeat_en.
   logic             repeat_en;
`endif
   logic             sh_load;
   logic [7:0]       sh_data;
   logic [1:0]       sh_func;
   logic             busy;
   logic             done;
   logic [3:0]       step_cnt;

   modport master (
`ifdef SHIFT_SEQ_REPEAT_EN
      output repeat_en,
`endif
      output start, stop, pattern, mode, steps, div,
      input  sh_load, sh_data, sh_func, busy, done, step_cnt
   );

   modport slave (
`ifdef SHIFT_SEQ_REPEAT_EN
      input  repeat_en,
`endif
      input  start, stop, pattern, mode, steps, div,
      output sh_load, sh_data, sh_func, busy, done, step_cnt
   );
endinterface

// File: rtl/shift_sequencer.sv
// Control FSM for the 8-bit LED shift register: loads a pattern, then issues timed shifts.
// Optional feature: SHIFT_SEQ_REPEAT_EN adds auto-restart of finite sequences.
module shift_sequencer #(
   parameter int DIV_W = 24
) (
   input logic               clk,
   input logic               clear,
   shift_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   localparam logic [1:0] MODE_HOLD   = 2'b00;
   localparam logic [1:0] MODE_RIGHT  = 2'b01;
   localparam logic [1:0] MODE_LEFT   = 2'b10;
   localparam logic [1:0] FUNC_NONE   = 2'b00;
   localparam logic [1:0] FUNC_RIGHT  = 2'b01;
   localparam logic [1:0] FUNC_LEFT   = 2'b10;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] presc_q, presc_d, div_q, div_d;
   logic [3:0]       step_cnt_q, step_cnt_d, steps_q, steps_d;
   logic [7:0]       pattern_q, pattern_d, sh_data_q, sh_data_d;
   logic [1:0]       mode_q, mode_d, func_q, func_d;
   logic [2:0]       pos_q, pos_d;
   logic             dir_q, dir_d;
   logic             sh_load_q, sh_load_d, busy_q, busy_d, done_q, done_d;
`ifdef SHIFT_SEQ_REPEAT_EN
   logic             repeat_q, repeat_d;
`endif
   logic             tick;

   function automatic logic [1:0] dir_func(input logic [1:0] mode, input logic dir_left);
      case (mode)
         MODE_HOLD:  return FUNC_NONE;
         MODE_RIGHT: return FUNC_RIGHT;
         MODE_LEFT:  return FUNC_LEFT;
         default:    return dir_left ? FUNC_LEFT : FUNC_RIGHT;
      endcase
   endfunction

   assign tick = (state_q == RUN) && (presc_q == div_q);

   always_comb begin
      // NOTE: every variable gets a default before the case, so no path can infer a latch.
      state_d    = state_q;
      presc_d    = presc_q;
      div_d      = div_q;
      step_cnt_d = step_cnt_q;
      steps_d    = steps_q;
      pattern_d  = pattern_q;
      mode_d     = mode_q;
      pos_d      = pos_q;
      dir_d      = dir_q;
`ifdef SHIFT_SEQ_REPEAT_EN
      repeat_d   = repeat_q;
`endif
      sh_load_d  = 1'b0;
      sh_data_d  = 8'h00;
      func_d     = FUNC_NONE;
      busy_d     = 1'b0;
      done_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               pattern_d  = bus.pattern;
               mode_d     = bus.mode;
               steps_d    = bus.steps;
               div_d      = bus.div;
`ifdef SHIFT_SEQ_REPEAT_EN
               repeat_d   = bus.repeat_en;
`endif
               step_cnt_d = 4'd0;
               state_d    = LOAD;
               sh_load_d  = 1'b1;
               sh_data_d  = bus.pattern;
               busy_d     = 1'b1;
            end
         end
         LOAD: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else begin
               state_d    = RUN;
               presc_d    = '0;
               step_cnt_d = 4'd0;
               dir_d      = 1'b0;
               pos_d      = 3'd0;
               busy_d     = 1'b1;
               if (div_q == '0) func_d = dir_func(mode_q, 1'b0);
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else begin
               busy_d = 1'b1;
               if (tick) begin
                  presc_d    = '0;
                  step_cnt_d = step_cnt_q + 4'd1;
                  // Bounce flips direction after seven shifts each way.
                  if (mode_q == 2'b11) begin
                     if (pos_q == 3'd6) begin
                        pos_d = 3'd0;
                        dir_d = ~dir_q;
                     end else begin
                        pos_d = pos_q + 3'd1;
                     end
                  end
                  if ((steps_q != 4'd0) && (step_cnt_d == steps_q)) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else if (div_q == '0) begin
                     func_d = dir_func(mode_q, dir_d);
                  end
               end else begin
                  presc_d = presc_q + DIV_W'(1);
                  if (presc_d == div_q) func_d = dir_func(mode_q, dir_q);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
`ifdef SHIFT_SEQ_REPEAT_EN
            if (repeat_q) begin
               state_d    = LOAD;
               step_cnt_d = 4'd0;
               sh_load_d  = 1'b1;
               sh_data_d  = pattern_q;
               busy_d     = 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q    <= IDLE;
         presc_q    <= '0;
         div_q      <= '0;
         step_cnt_q <= 4'd0;
         steps_q    <= 4'd0;
         pattern_q  <= 8'h00;
         mode_q     <= MODE_HOLD;
         pos_q      <= 3'd0;
         dir_q      <= 1'b0;
`ifdef SHIFT_SEQ_REPEAT_EN
         repeat_q   <= 1'b0;
`endif
         sh_load_q  <= 1'b0;
         sh_data_q  <= 8'h00;
         func_q     <= FUNC_NONE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
         state_q    <= state_d;
         presc_q    <= presc_d;
         div_q      <= div_d;
         step_cnt_q <= step_cnt_d;
         steps_q    <= steps_d;
         pattern_q  <= pattern_d;
         mode_q     <= mode_d;
         pos_q      <= pos_d;
         dir_q      <= dir_d;
`ifdef SHIFT_SEQ_REPEAT_EN
         repeat_q   <= repeat_d;
`endif
         sh_load_q  <= sh_load_d;
         sh_data_q  <= sh_data_d;
         func_q     <= func_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.sh_load  = sh_load_q;
   assign bus.sh_data  = sh_data_q;
   // A stop arriving in a tick cycle must cancel that cycle's shift.
   assign bus.sh_func  = bus.stop ? FUNC_NONE : func_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.step_cnt = step_cnt_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: cycle tables plus hand-written corner sequences.
module tb_shift_sequencer;
   logic clk = 1'b0;
   logic clear = 1'b1;
   int   checks = 0;
   int   errors = 0;

   shift_sequencer_if #(.DIV_W(24)) bus ();
   shift_sequencer #(.DIV_W(24)) dut (.clk(clk), .clear(clear), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       start, stop;
      logic [7:0] pattern;
      logic [1:0] mode;
      logic [3:0] steps;
      logic [23:0] div;
      logic       sh_load;
      logic [7:0] sh_data;
      logic [1:0] sh_func;
      logic       busy, done;
      logic [3:0] step_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic vec_t v(string n, logic st, logic sp, logic [7:0] pat, logic [1:0] md,
                              logic [3:0] stp, logic [23:0] dv, logic ld, logic [7:0] dat,
                              logic [1:0] fn, logic bsy, logic dn, logic [3:0] sc);
      vec_t r;
      r.name = n; r.start = st; r.stop = sp; r.pattern = pat; r.mode = md; r.steps = stp;
      r.div = dv; r.sh_load = ld; r.sh_data = dat; r.sh_func = fn; r.busy = bsy;
      r.done = dn; r.step_cnt = sc;
      return r;
   endfunction

   function automatic logic [31:0] outs();
      return 32'({bus.sh_load, bus.sh_data, bus.sh_func, bus.busy, bus.done, bus.step_cnt});
   endfunction

   task automatic drive(input logic st, input logic sp, input logic [7:0] pat,
                        input logic [1:0] md, input logic [3:0] stp, input logic [23:0] dv);
      bus.start = st; bus.stop = sp; bus.pattern = pat; bus.mode = md;
      bus.steps = stp; bus.div = dv;
   endtask

   initial begin
      drive(1'b0, 1'b0, 8'h00, 2'b00, 4'd0, 24'd0);
`ifdef SHIFT_SEQ_REPEAT_EN
      bus.repeat_en = 1'b0;
`endif
      #12;
      check("reset_outputs", outs(), 32'd0);
      @(posedge clk); #1 clear = 1'b0;

      // Right run, then left run with prescaler; inputs after start are noise to be ignored.
      vecs.push_back(v("r0", 1, 0, 8'h80, 2'd1, 4'd3, 24'd0, 0, 8'h00, 2'd0, 0, 0, 4'd0));
      vecs.push_back(v("r1", 0, 0, 8'h3C, 2'd2, 4'd7, 24'd5, 1, 8'h80, 2'd0, 1, 0, 4'd0));
      vecs.push_back(v("r2", 0, 0, 8'h3C, 2'd2, 4'd7, 24'd5, 0, 8'h00, 2'd1, 1, 0, 4'd0));
      vecs.push_back(v("r3", 0, 0, 8'h3C, 2'd2, 4'd7, 24'd5, 0, 8'h00, 2'd1, 1, 0, 4'd1));
      vecs.push_back(v("r4", 0, 0, 8'h3C, 2'd2, 4'd7, 24'd5, 0, 8'h00, 2'd1, 1, 0, 4'd2));
      vecs.push_back(v("r5", 0, 0, 8'h3C, 2'd2, 4'd7, 24'd5, 0, 8'h00, 2'd0, 1, 1, 4'd3));
      vecs.push_back(v("r6", 0, 0, 8'h3C, 2'd2, 4'd7, 24'd5, 0, 8'h00, 2'd0, 0, 0, 4'd3));
      vecs.push_back(v("p0", 1, 0, 8'h0F, 2'd2, 4'd2, 24'd3, 0, 8'h00, 2'd0, 0, 0, 4'd3));
      vecs.push_back(v("p1", 0, 0, 8'h00, 2'd0, 4'd0, 24'd0, 1, 8'h0F, 2'd0, 1, 0, 4'd0));
      vecs.push_back(v("p2", 0, 0, 8'h00, 2'd0, 4'd0, 24'd0, 0, 8'h00, 2'd0, 1, 0, 4'd0));
      vecs.push_back(v("p3", 1, 0, 8'hAA, 2'd1, 4'd1, 24'd0, 0, 8'h00, 2'd0, 1, 0, 4'd0));
      vecs.push_back(v("p4", 0, 0, 8'h00, 2'd0, 4'd0, 24'd0, 0, 8'h00, 2'd0, 1, 0, 4'd0));
      vecs.push_back(v("p5", 0, 0, 8'h00, 2'd0, 4'd0, 24'd0, 0, 8'h00, 2'd2, 1, 0, 4'd0));
      vecs.push_back(v("p6", 0, 0, 8'h00, 2'd0, 4'd0, 24'd0, 0, 8'h00, 2'd0, 1, 0, 4'd1));
      vecs.push_back(v("p7", 0, 0, 8'h00, 2'd0, 4'd0, 24'd0, 0, 8'h00, 2'd0, 1, 0, 4'd1));
      vecs.push_back(v("p8", 0, 0, 8'h00, 2'd0, 4'd0, 24'd0, 0, 8'h00, 2'd0, 1, 0, 4'd1));
      vecs.push_back(v("p9", 0, 0, 8'h00, 2'd0, 4'd0, 24'd0, 0, 8'h00, 2'd2, 1, 0, 4'd1));
      vecs.push_back(v("p10", 0, 0, 8'h00, 2'd0, 4'd0, 24'd0, 0, 8'h00, 2'd0, 1, 1, 4'd2));
      vecs.push_back(v("p11", 0, 1, 8'h00, 2'd0, 4'd0, 24'd0, 0, 8'h00, 2'd0, 0, 0, 4'd2));
      vecs.push_back(v("p12", 0, 0, 8'h00, 2'd0, 4'd0, 24'd0, 0, 8'h00, 2'd0, 0, 0, 4'd2));

      foreach (vecs[i]) begin
         drive(vecs[i].start, vecs[i].stop, vecs[i].pattern, vecs[i].mode,
               vecs[i].steps, vecs[i].div);
         @(negedge clk);
         check(vecs[i].name, outs(),
               32'({vecs[i].sh_load, vecs[i].sh_data, vecs[i].sh_func,
                    vecs[i].busy, vecs[i].done, vecs[i].step_cnt}));
         @(posedge clk); #1;
      end

      // Bounce, endless: 7 rights, 7 lefts, repeat; step_cnt wraps at 16 ticks.
      drive(1'b1, 1'b0, 8'h01, 2'd3, 4'd0, 24'd0);
      @(posedge clk); #1 bus.start = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("bounce_func%0d", i), 32'(bus.sh_func),
               ((i / 7) % 2 == 0) ? 32'd1 : 32'd2);
         check($sformatf("bounce_cnt%0d", i), 32'(bus.step_cnt), 32'(i % 16));
         @(posedge clk); #1;
      end
      // Stop lands on a tick: shift suppressed, no done, idle next cycle.
      bus.stop = 1'b1;
      @(negedge clk);
      check("stop_tick_func", 32'(bus.sh_func), 32'd0);
      check("stop_tick_done", 32'(bus.done), 32'd0);
      @(posedge clk); #1 bus.stop = 1'b0;
      @(negedge clk);
      check("stop_idle_busy", 32'({bus.busy, bus.done}), 32'd0);
      @(posedge clk); #1;

      // Asynchronous clear in the middle of a right run with div=5.
      drive(1'b1, 1'b0, 8'h55, 2'd1, 4'd0, 24'd5);
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      check("pre_clear_busy", 32'(bus.busy), 32'd1);
      check("pre_clear_cnt", 32'(bus.step_cnt), 32'd1);
      #2 clear = 1'b1;
      #1;
      check("clear_busy", 32'(bus.busy), 32'd0);
      check("clear_func", 32'(bus.sh_func), 32'd0);
      check("clear_load", 32'(bus.sh_load), 32'd0);
      check("clear_done", 32'(bus.done), 32'd0);
      check("clear_cnt", 32'(bus.step_cnt), 32'd0);
      repeat (2) @(posedge clk);
      #1 clear = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("post_clear%0d", i), outs(), 32'd0);
      end
      @(posedge clk); #1;

`ifdef SHIFT_SEQ_REPEAT_EN
      // Repeat: LOAD, RUN, RUN, DONE cycle of four, until stop.
      drive(1'b1, 1'b0, 8'hC3, 2'd1, 4'd2, 24'd0);
      bus.repeat_en = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      bus.repeat_en = 1'b0;
      for (int c = 1; c < 14; c++) begin
         @(negedge clk);
         check($sformatf("rep_done%0d", c), 32'(bus.done), (c % 4 == 0) ? 32'd1 : 32'd0);
         check($sformatf("rep_load%0d", c), 32'({bus.sh_load, bus.sh_data}),
               (c % 4 == 1) ? 32'h1C3 : 32'h0);
         @(posedge clk); #1;
      end
      bus.stop = 1'b1;
      @(posedge clk); #1 bus.stop = 1'b0;
      @(negedge clk);
      check("rep_stop_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
